cdb_result_buffer: RTL
======================

Name: cdb_result_buffer

Overview:
- Per-functional-unit result FIFO between an execution unit (ALU, MUL, MEM or BRANCH) and the CDB arbiter.
- Captures completed results so that a result losing CDB arbitration is held, not dropped.
- Presents the oldest entry as that unit's CDB request (`*_valid` plus payload).
- Pops the oldest entry in the cycle the arbiter grants it.
- Back-pressures the unit when full.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- XLEN, `XLEN, result and PC width.
- PRF_LEN, `PRF_LEN, physical register index width.
- ROB_LEN, `ROB_LEN, ROB index width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  mispredict squash; discards all entries.
- in_valid  in  1  FU has a completed result this cycle.
- in_value  in  XLEN  result value.
- in_prf_idx  in  PRF_LEN  destination physical register.
- in_rob_idx  in  ROB_LEN  ROB entry.
- in_PC  in  XLEN  instruction PC.
- in_ready  out  1  buffer can accept a push; equals (count < DEPTH).
- out_valid  out  1  CDB request; equals (count != 0).
- out_value  out  XLEN  head value.
- out_prf_idx  out  PRF_LEN  head destination register.
- out_rob_idx  out  ROB_LEN  head ROB entry.
- out_PC  out  XLEN  head PC.
- cdb_grant  in  1  this unit's bit of the CDB arbiter's select, same cycle as out_valid.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Storage: circular array of DEPTH entries {value, prf_idx, rob_idx, PC}.
- Pointers: head_ptr and tail_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH.
- Counter: count, 0..DEPTH.
- Reset (reset==0, asynchronous): head_ptr=0, tail_ptr=0, count=0.
  - Resulting outputs: out_valid=0, in_ready=1.
  - Array contents are don't-care.
  - Reset asserted mid-operation discards all entries immediately, with no clock edge required.
- push = in_valid && in_ready:
  - Writes the entry at tail_ptr; tail_ptr+1 at the next posedge.
  - in_valid while in_ready==0 is ignored. The FU must hold its result and stall; the buffer never overwrites.
- pop = cdb_grant && out_valid:
  - head_ptr+1 at the next posedge.
  - cdb_grant while out_valid==0 is ignored.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop:
  - Legal at any occupancy below DEPTH.
  - When count==DEPTH, in_ready==0, so no push occurs even with a same-cycle pop. in_ready is never combinationally dependent on cdb_grant.
  - When count==0 and in_valid: the push is written; there is no pop, since out_valid is 0. No bypass.
- Latency: a pushed result is visible on out_* one cycle after the push edge. Minimum FU-to-CDB-register latency is 2 cycles.
- Head outputs are combinational reads of entry[head_ptr] while out_valid==1. While empty, the outputs are forced:
  - out_value=0
  - out_prf_idx=0
  - out_rob_idx=0
  - out_PC=XLEN'hfacebeec
- Order: strict FIFO. Results leave in push order.
- flush (synchronous, highest priority after reset):
  - At the posedge: head_ptr=0, tail_ptr=0, count=0.
  - A same-cycle push and a same-cycle pop are both discarded.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble. A full buffer has head_ptr==tail_ptr, disambiguated by count.

Decomposition:
- Shared package:
  - typedef cdb_entry_t {value, prf_idx, rob_idx, PC}.
  - Constant CDB_IDLE_PC = XLEN'hfacebeec, shared with the CDB's idle value.
- No sub-module. The pointer and counter logic is small enough to stay inline.
- One instance per FU; the top level connects each out_valid to the matching CDB request input and the matching select bit to cdb_grant.

Test Plan:
- Reset: drive reset=0 mid-stream with 2 entries held -> out_valid=0, count=0, in_ready=1, out_PC=32'hfacebeec immediately, before any clock edge.
- Basic pass-through:
  - Push {value=0x11, prf=5, rob=3, PC=0x100} with cdb_grant held 1 -> out_valid rises one cycle after the push with those exact fields.
  - The entry pops on the next edge; count returns 0.
- Fill and stall:
  - DEPTH=4, grant=0, push 0xA,0xB,0xC,0xD -> count=4, in_ready=0.
  - Fifth push of 0xE is ignored.
  - Grant 4 cycles -> 0xA,0xB,0xC,0xD emerge in order; 0xE is never seen.
- Simultaneous push and pop at count=2 -> count stays 2; 6 alternating push/pop cycles wrap pointers past index 3 with no data loss or reordering.
- Flush:
  - 3 entries held; assert flush with in_valid=1 and cdb_grant=1 in the same cycle -> next cycle count=0, out_valid=0.
  - The pushed entry never appears.
- Spurious grant: cdb_grant=1 while empty for 3 cycles -> count stays 0 and pointers are unchanged; a subsequent single push is delivered intact.

Source files
------------

// File: rtl/cdb_result_buffer_pkg.sv
// Shared types and constants for the per-functional-unit CDB result buffers.
package cdb_result_buffer_pkg;

    localparam int CDB_XLEN    = 32;
    localparam int CDB_PRF_LEN = 6;
    localparam int CDB_ROB_LEN = 5;

    // Idle PC the CDB drives when nothing is broadcast; kept identical here.
    localparam logic [CDB_XLEN-1:0] CDB_IDLE_PC = 32'hfacebeec;

    typedef struct packed {
        logic [CDB_XLEN-1:0]    value;
        logic [CDB_PRF_LEN-1:0] prf_idx;
        logic [CDB_ROB_LEN-1:0] rob_idx;
        logic [CDB_XLEN-1:0]    pc;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_result_buffer.sv
// Result FIFO between one execution unit and the CDB arbiter: holds results that
// lose arbitration, presents the oldest as the unit's CDB request, pops on grant.
module cdb_result_buffer
    import cdb_result_buffer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int XLEN    = CDB_XLEN,
    parameter int PRF_LEN = CDB_PRF_LEN,
    parameter int ROB_LEN = CDB_ROB_LEN
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          in_value,
    input  logic [PRF_LEN-1:0]       in_prf_idx,
    input  logic [ROB_LEN-1:0]       in_rob_idx,
    input  logic [XLEN-1:0]          in_PC,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_value,
    output logic [PRF_LEN-1:0]       out_prf_idx,
    output logic [ROB_LEN-1:0]       out_rob_idx,
    output logic [XLEN-1:0]          out_PC,
    input  logic                     cdb_grant,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // Entries use the shared struct, so the field widths must agree with it.
    if (XLEN != CDB_XLEN || PRF_LEN != CDB_PRF_LEN || ROB_LEN != CDB_ROB_LEN
        || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
        $error("cdb_result_buffer: unsupported parameter combination");
    end

    cdb_entry_t             entries_q [DEPTH];
    cdb_entry_t             head_entry;
    logic [PTR_W-1:0]       head_ptr_q, head_ptr_d;
    logic [PTR_W-1:0]       tail_ptr_q, tail_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   push;
    logic                   pop;

    // in_ready depends only on registered occupancy, never on cdb_grant.
    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        push       = in_valid && in_ready;
        pop        = cdb_grant && out_valid;
        head_ptr_d = head_ptr_q;
        tail_ptr_d = tail_ptr_q;
        count_d    = count_q;
        if (flush) begin
            head_ptr_d = '0;
            tail_ptr_d = '0;
            count_d    = '0;
        end else begin
            if (push) tail_ptr_d = tail_ptr_q + PTR_W'(1);
            if (pop)  head_ptr_d = head_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_ptr_q <= '0;
            tail_ptr_q <= '0;
            count_q    <= '0;
        end else begin
            head_ptr_q <= head_ptr_d;
            tail_ptr_q <= tail_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: the entry array is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            entries_q[tail_ptr_q] <= '{value: in_value, prf_idx: in_prf_idx,
                                       rob_idx: in_rob_idx, pc: in_PC};
        end
    end

    assign head_entry = entries_q[head_ptr_q];

    // Empty buffer presents the CDB idle pattern instead of stale array data.
    always_comb begin
        out_value   = '0;
        out_prf_idx = '0;
        out_rob_idx = '0;
        out_PC      = CDB_IDLE_PC;
        if (out_valid) begin
            out_value   = head_entry.value;
            out_prf_idx = head_entry.prf_idx;
            out_rob_idx = head_entry.rob_idx;
            out_PC      = head_entry.pc;
        end
    end

endmodule
